multicycle_controller: RTL



---
 rtl/multicycle_controller.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle function decoder: accepts one func/dest per handshake and sequences it to writeback.
// Optional macro INSTR_COUNT_EN adds a 16-bit retired-instruction counter output.
//
// state  | meaning
// IDLE   | ready for a new instruction
// EXEC   | executing; MUL stays here for MUL_LAT cycles
// WB     | one-cycle writeback, done pulse
module multicycle_controller #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int MUL_LAT  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [3:0]          func,
  input  logic [ADDR_W-1:0]   dest,
  output logic [1:0]          muxsel,
  output logic [1:0]          alu_op,
  output logic [NUM_REGS-1:0] we_reg,
  output logic                we_mem,
  output logic                busy,
  output logic                done,
  output logic                illegal
`ifdef INSTR_COUNT_EN
  ,
  output logic [15:0]         instr_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  localparam logic [3:0] F_NOP   = 4'b0000;
  localparam logic [3:0] F_ADD   = 4'b0001;
  localparam logic [3:0] F_SUB   = 4'b0010;
  localparam logic [3:0] F_AND   = 4'b0011;
  localparam logic [3:0] F_LDI   = 4'b0100;
  localparam logic [3:0] F_MUL   = 4'b0101;
  localparam logic [3:0] F_STORE = 4'b0110;

  state_t              state_q, state_d;
  logic [3:0]          func_q;
  logic [ADDR_W-1:0]   dest_q;
  logic [7:0]          cnt_q, cnt_d;
  logic                accept;
  logic                ill_q;

  function automatic logic writes_reg(input logic [3:0] f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_LDI) || (f == F_MUL);
  endfunction

  function automatic logic is_illegal(input logic [3:0] f, input logic [ADDR_W-1:0] d);
    logic [31:0] d_ext;
    d_ext = {{(32-ADDR_W){1'b0}}, d};
    return f[3] || (f == 4'b0111) || (writes_reg(f) && (d_ext >= 32'(NUM_REGS)));
  endfunction

  // NOP and illegal instructions skip EXEC and go straight to writeback.
  function automatic logic needs_exec(input logic [3:0] f, input logic [ADDR_W-1:0] d);
    return !is_illegal(f, d) && (f != F_NOP);
  endfunction

  assign accept = instr_valid && instr_ready;
  assign ill_q  = is_illegal(func_q, dest_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      func_q  <= '0;
      dest_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        func_q <= func;
        dest_q <= dest;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (needs_exec(func, dest)) begin
            state_d = S_EXEC;
            cnt_d   = 8'd1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_EXEC: begin
        if ((func_q == F_MUL) && (cnt_q != 8'(MUL_LAT))) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    muxsel      = 2'd0;
    alu_op      = 2'd0;
    we_reg      = '0;
    we_mem      = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    if (state_q != S_IDLE && !ill_q) begin
      case (func_q)
        F_ADD:   alu_op = 2'd0;
        F_SUB:   alu_op = 2'd1;
        F_AND:   alu_op = 2'd2;
        F_LDI:   muxsel = 2'd1;
        F_MUL:   muxsel = 2'd2;
        default: muxsel = 2'd0;
      endcase
    end
    if (state_q == S_WB) begin
      done    = 1'b1;
      illegal = ill_q;
      we_mem  = !ill_q && (func_q == F_STORE);
      // Register 0 is hardwired zero, so bit 0 of we_reg is never driven.
      if (!ill_q && writes_reg(func_q)) begin
        for (int i = 1; i < NUM_REGS; i++) begin
          if (dest_q == ADDR_W'(i)) we_reg[i] = 1'b1;
        end
      end
    end
  end

`ifdef INSTR_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= 16'd0;
    end else if (state_q == S_WB) begin
      instr_count <= instr_count + 16'd1;
    end
  end
`endif

endmodule
